// File: rtl/con_uart_dump_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : con_uart_dump_if                                                 |
// | Brief   : Controller-port bundle (address, byte enables, write/read data). |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface con_uart_dump_if #(
    parameter int ADDR_BITS = 14
);
    logic [ADDR_BITS-1:0] con_addr;
    logic [3:0]           con_write;
    logic [31:0]          con_in;
    logic [31:0]          con_out;

    modport master (output con_addr, output con_write, output con_in, input  con_out);
    modport slave  (input  con_addr, input  con_write, input  con_in, output con_out);
endinterface
`default_nettype wire

// File: rtl/con_uart_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : con_uart_dump                                                    |
// | Brief   : Reads a block of core-memory words and streams them big-endian   |
// |           over an 8N1 UART, then posts a completion status word.           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module con_uart_dump #(
    parameter int                   CLKS_PER_BIT = 868,
    parameter int                   ADDR_BITS    = 14,
    parameter logic [ADDR_BITS-1:0] STATUS_ADDR  = 14'h2000
) (
    input  wire logic                 con_clk,
    input  wire logic                 rst,
    input  wire logic                 start,
    input  wire logic [ADDR_BITS-1:0] start_addr,
    input  wire logic [ADDR_BITS-2:0] word_count,
    con_uart_dump_if.master           con,
    output logic                      uart_tx,
    output logic                      busy,
    output logic                      done
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_READ    = 3'd1;
    localparam logic [2:0] c_ST_CAPTURE = 3'd2;
    localparam logic [2:0] c_ST_TX      = 3'd3;
    localparam logic [2:0] c_ST_STATUS  = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;

    localparam int                     c_CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0]     c_CNT_MAX   = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]             c_STOP_BIT  = 4'd9;
    localparam logic [ADDR_BITS-1:0]   c_CORE_MASK = {1'b0, {(ADDR_BITS-1){1'b1}}};
    localparam logic [ADDR_BITS-2:0]   c_ONE       = (ADDR_BITS-1)'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [ADDR_BITS-1:0] r_addr;
    logic [ADDR_BITS-1:0] r_last_addr;
    logic [ADDR_BITS-2:0] r_remaining;
    logic [ADDR_BITS-2:0] r_sent;
    logic [31:0]          r_shift_word;
    logic [1:0]           r_byte_idx;
    logic [3:0]           r_bit_idx;
    logic [c_CNT_W-1:0]   r_clk_cnt;
    logic                 w_bit_end;
    logic                 w_word_end;
    logic [7:0]           w_cur_byte;
    logic [2:0]           w_data_idx;

    assign w_bit_end  = (r_clk_cnt == c_CNT_MAX);
    assign w_word_end = (r_state == c_ST_TX) && w_bit_end &&
                        (r_bit_idx == c_STOP_BIT) && (r_byte_idx == 2'd3);
    // The outgoing byte is always the top byte; the word shifts left after each stop bit.
    assign w_cur_byte = r_shift_word[31:24];
    assign w_data_idx = 3'(r_bit_idx - 4'd1);

    always_ff @(posedge con_clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:    if (start) w_next_state = (word_count == '0) ? c_ST_STATUS : c_ST_READ;
            c_ST_READ:    w_next_state = c_ST_CAPTURE;
            c_ST_CAPTURE: w_next_state = c_ST_TX;
            c_ST_TX:      if (w_word_end) w_next_state = (r_remaining == c_ONE) ? c_ST_STATUS : c_ST_READ;
            c_ST_STATUS:  w_next_state = c_ST_DONE;
            c_ST_DONE:    w_next_state = c_ST_IDLE;
            default:      w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        uart_tx       = 1'b1;
        busy          = (r_state != c_ST_IDLE);
        done          = (r_state == c_ST_DONE);
        con.con_addr  = r_last_addr;
        con.con_write = 4'h0;
        con.con_in    = 32'h0;
        case (r_state)
            c_ST_READ: con.con_addr = r_addr;
            c_ST_TX: begin
                if (r_bit_idx == 4'd0) begin
                    uart_tx = 1'b0;
                end else if (r_bit_idx != c_STOP_BIT) begin
                    uart_tx = w_cur_byte[w_data_idx];
                end
            end
            c_ST_STATUS: begin
                con.con_addr  = STATUS_ADDR;
                con.con_write = 4'hF;
                con.con_in    = {1'b1, {(32-ADDR_BITS){1'b0}}, r_sent};
            end
            default: ;
        endcase
    end

    always_ff @(posedge con_clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_last_addr  <= '0;
            r_remaining  <= '0;
            r_sent       <= '0;
            r_shift_word <= '0;
            r_byte_idx   <= '0;
            r_bit_idx    <= '0;
            r_clk_cnt    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        // Reads always target core memory, so the region-select bit is dropped.
                        r_addr      <= start_addr & c_CORE_MASK;
                        r_remaining <= word_count;
                        r_sent      <= '0;
                    end
                end
                c_ST_READ: r_last_addr <= r_addr;
                c_ST_CAPTURE: begin
                    r_shift_word <= con.con_out;
                    r_byte_idx   <= '0;
                    r_bit_idx    <= '0;
                    r_clk_cnt    <= '0;
                end
                c_ST_TX: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == c_STOP_BIT) begin
                            r_bit_idx    <= '0;
                            r_byte_idx   <= r_byte_idx + 2'd1;
                            r_shift_word <= {r_shift_word[23:0], 8'h00};
                            if (r_byte_idx == 2'd3) begin
                                r_sent      <= r_sent + c_ONE;
                                r_remaining <= r_remaining - c_ONE;
                                r_addr      <= {1'b0, r_addr[ADDR_BITS-2:0] + c_ONE};
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_STATUS: r_last_addr <= STATUS_ADDR;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_con_uart_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_con_uart_dump                                                 |
// | Brief   : Self-checking bench: vector table, random transfers, reset case. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_con_uart_dump;

    localparam int CPB  = 4;
    localparam int P    = 10 * CPB * 4 + 2;   // cycles per word incl. READ+CAPTURE
    localparam int MAXK = 800;

    logic        con_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        start   = 1'b0;
    logic [13:0] start_addr = '0;
    logic [12:0] word_count = '0;
    logic        uart_tx, busy, done;

    always #5 con_clk = ~con_clk;

    con_uart_dump_if #(.ADDR_BITS(14)) bus ();

    con_uart_dump #(.CLKS_PER_BIT(CPB), .ADDR_BITS(14), .STATUS_ADDR(14'h2000)) dut (
        .con_clk    (con_clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .con        (bus),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .done       (done)
    );

    logic [31:0] mem [0:8191];
    always @(posedge con_clk) bus.con_out <= mem[bus.con_addr[12:0]];

    logic        lg_tx   [MAXK];
    logic        lg_busy [MAXK];
    logic        lg_done [MAXK];
    logic [3:0]  lg_we   [MAXK];
    logic [13:0] lg_addr [MAXK];
    logic [31:0] lg_in   [MAXK];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [13:0] sa;
        int          cnt;
        int          inject;
        logic [13:0] exp_first;
        logic [31:0] exp_status;
        int          exp_done;
        string       tag;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [13:0] sa, input int wi);
        return mem[(int'(sa[12:0]) + wi) % 8192];
    endfunction

    // Expected line level k cycles after start acceptance, for k before the status cycle.
    function automatic logic exp_tx(input int k, input logic [13:0] sa);
        int wi, o, bitn, byn, b;
        logic [31:0] word;
        logic [7:0]  byv;
        wi = (k - 1) / P;
        o  = (k - 1) % P;
        if (o < 2) return 1'b1;
        bitn = (o - 2) / CPB;
        byn  = bitn / 10;
        b    = bitn % 10;
        word = word_at(sa, wi);
        byv  = 8'(word >> (8 * (3 - byn)));
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return byv[b-1];
    endfunction

    task automatic run_xfer(input vec_t v);
        int sk, last, bad_k, ndone, errs;
        logic [7:0] exq[$];
        logic [7:0] dq[$];
        logic [31:0] w;
        bit ok;
        sk   = (v.cnt == 0) ? 1 : P * v.cnt + 1;
        last = sk + 3;
        @(negedge con_clk);
        start = 1'b1; start_addr = v.sa; word_count = 13'(v.cnt);
        @(posedge con_clk);
        #1 start = 1'b0;
        for (int k = 1; k <= last; k++) begin
            @(negedge con_clk);
            lg_tx[k] = uart_tx; lg_busy[k] = busy; lg_done[k] = done;
            lg_we[k] = bus.con_write; lg_addr[k] = bus.con_addr; lg_in[k] = bus.con_in;
            if (k == v.inject) begin
                start = 1'b1; start_addr = 14'h0100; word_count = 13'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;

        bad_k = 0;
        for (int k = last; k >= 1; k--)
            if (lg_tx[k] !== ((k < sk) ? exp_tx(k, v.sa) : 1'b1)) bad_k = k;
        check(bad_k == 0, {v.tag, "/uart_wave_first_bad_cycle"}, bad_k, 0);

        errs = 0;
        for (int wi = 0; wi < v.cnt; wi++)
            if (lg_addr[wi*P+1] !== 14'((int'(v.sa[12:0]) + wi) % 8192)) errs++;
        check(errs == 0, {v.tag, "/read_addrs_bad"}, errs, 0);
        if (v.cnt > 0)
            check(lg_addr[1] === v.exp_first, {v.tag, "/first_read_addr"}, lg_addr[1], v.exp_first);

        ok = (lg_we[sk] === 4'hF) && (lg_addr[sk] === 14'h2000) && (lg_in[sk] === v.exp_status);
        check(ok, {v.tag, "/status_write_in"}, lg_in[sk], v.exp_status);

        errs = 0;
        for (int k = 1; k <= last; k++)
            if (k != sk && (lg_we[k] !== 4'h0 || lg_in[k] !== 32'h0)) errs++;
        check(errs == 0, {v.tag, "/stray_write_cycles"}, errs, 0);

        ndone = 0;
        for (int k = 1; k <= last; k++) if (lg_done[k] === 1'b1) ndone++;
        check(ndone == 1 && lg_done[v.exp_done] === 1'b1, {v.tag, "/done_pulse_count"}, ndone, 1);

        errs = 0;
        for (int k = 1; k <= last; k++)
            if (lg_busy[k] !== (k <= sk + 1)) errs++;
        check(errs == 0, {v.tag, "/busy_profile_bad"}, errs, 0);

        for (int wi = 0; wi < v.cnt; wi++) begin
            w = word_at(v.sa, wi);
            exq.push_back(w[31:24]); exq.push_back(w[23:16]);
            exq.push_back(w[15:8]);  exq.push_back(w[7:0]);
        end
        for (int i = 1; i < sk; i++) begin
            if (lg_tx[i] === 1'b0 && i + 10*CPB < MAXK) begin
                logic [7:0] d;
                for (int j = 1; j <= 8; j++) d[j-1] = lg_tx[i + CPB*j + CPB/2];
                dq.push_back(d);
                i = i + 10*CPB - 1;
            end
        end
        ok = (dq.size() == exq.size());
        if (ok) foreach (dq[i]) if (dq[i] !== exq[i]) ok = 1'b0;
        check(ok, {v.tag, "/decoded_bytes_count"}, dq.size(), exq.size());
    endtask

    initial begin
        vec_t rv;
        int   errs;
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        mem[14'h0010] = 32'h1234_5678;

        vecs[0] = '{14'h0010, 1, 0,   14'h0010, 32'h8000_0001, 164, "basic"};
        vecs[1] = '{14'h0000, 0, 0,   14'h0000, 32'h8000_0000, 2,   "zero_count"};
        vecs[2] = '{14'h1FFF, 2, 0,   14'h1FFF, 32'h8000_0002, 326, "wrap"};
        vecs[3] = '{14'h0040, 2, 60,  14'h0040, 32'h8000_0002, 326, "start_busy"};
        vecs[4] = '{14'h2005, 1, 0,   14'h0005, 32'h8000_0001, 164, "bit13"};
        vecs[5] = '{14'h0030, 1, 164, 14'h0030, 32'h8000_0001, 164, "start_in_done"};

        repeat (3) @(negedge con_clk);
        check(uart_tx === 1'b1 && bus.con_write === 4'h0 && bus.con_addr === 14'h0 &&
              bus.con_in === 32'h0 && busy === 1'b0 && done === 1'b0,
              "reset_outputs", {uart_tx, busy, done, bus.con_write}, 32'h40);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) run_xfer(vecs[t]);

        for (int t = 0; t < 6; t++) begin
            rv.sa         = 14'($urandom_range(0, 16383));
            rv.cnt        = $urandom_range(0, 3);
            rv.inject     = 0;
            rv.exp_first  = rv.sa & 14'h1FFF;
            rv.exp_status = 32'h8000_0000 | 32'(rv.cnt);
            rv.exp_done   = (rv.cnt == 0) ? 2 : P * rv.cnt + 2;
            rv.tag        = $sformatf("rand%0d", t);
            run_xfer(rv);
        end

        // Reset during the second data bit of the second byte.
        @(negedge con_clk);
        start = 1'b1; start_addr = 14'h0020; word_count = 13'd1;
        @(posedge con_clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 51; k++) @(negedge con_clk);
        check(uart_tx === exp_tx(51, 14'h0020), "rst_pre_bit", uart_tx, exp_tx(51, 14'h0020));
        rst = 1'b1;
        @(negedge con_clk);
        check(uart_tx === 1'b1 && busy === 1'b0 && done === 1'b0 && bus.con_write === 4'h0 &&
              bus.con_addr === 14'h0 && bus.con_in === 32'h0,
              "rst_mid_outputs", {uart_tx, busy, done, bus.con_write}, 32'h40);
        rst = 1'b0;
        errs = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge con_clk);
            if (done !== 1'b0 || bus.con_write !== 4'h0 || busy !== 1'b0 || uart_tx !== 1'b1) errs++;
        end
        check(errs == 0, "rst_quiet_after", errs, 0);

        vecs[0].tag = "after_rst";
        run_xfer(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
